// File: rtl/dcache_controller_if.sv
// Bus bundle between the MEM stage, the data-cache controller and off-chip data memory.
// "slave" is the controller's view; "master" is the side that drives CPU requests and memory responses.
interface dcache_controller_if #(
    parameter int ADDR_W     = 32,
    parameter int BLOCK_BITS = 256
);
    logic                  cpu_req_i;
    logic                  cpu_we_i;
    logic [ADDR_W-1:0]     cpu_addr_i;
    logic [31:0]           cpu_wdata_i;
    logic [31:0]           cpu_rdata_o;
    logic                  cpu_stall_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [BLOCK_BITS-1:0] mem_wdata_o;
    logic [BLOCK_BITS-1:0] mem_rdata_i;
    logic                  mem_ack_i;

    // Memory side: mem_req_o/we/addr/wdata stay stable until the one-cycle mem_ack_i pulse;
    // mem_rdata_i is sampled only in the ack cycle. CPU side: an access completes in the cycle
    // cpu_req_i=1 and cpu_stall_o=0; addr/we/wdata are held while cpu_stall_o=1.
    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache: same-cycle hits, stalling misses that
// run an optional victim write-back followed by a line refill over a req/ack memory port.
module dcache_controller #(
    parameter int LINES      = 16,
    parameter int BLOCK_BITS = 256,
    parameter int ADDR_W     = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dcache_controller_if.slave  bus,
    output logic [1:0]          dbg_state_o
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - 5 - IDX_W;
    localparam int WSEL_W = $clog2(BLOCK_BITS / 32);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        ALLOC = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [LINES-1:0]      dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [TAG_W-1:0]      tag_d  [LINES];
    logic [BLOCK_BITS-1:0] data_q [LINES];
    logic [BLOCK_BITS-1:0] data_d [LINES];

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      addr_tag;
    logic [WSEL_W-1:0]     wsel;
    logic [1:0]            unused_addr;
    logic                  hit;

    logic [31:0]           rdata_c;
    logic                  stall_c;
    logic                  req_c;
    logic                  we_c;
    logic [ADDR_W-1:0]     addr_c;
    logic [BLOCK_BITS-1:0] wdata_c;

    assign idx         = bus.cpu_addr_i[5 +: IDX_W];
    assign addr_tag    = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel        = bus.cpu_addr_i[2 +: WSEL_W];
    assign unused_addr = bus.cpu_addr_i[1:0];
    assign hit         = bus.cpu_req_i & valid_q[idx] & (tag_q[idx] == addr_tag);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        rdata_c = '0;
        stall_c = 1'b0;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req_i) begin
                    if (hit) begin
                        if (bus.cpu_we_i) begin
                            data_d[idx][{wsel, 5'b0} +: 32] = bus.cpu_wdata_i;
                            dirty_d[idx] = 1'b1;
                        end else begin
                            rdata_c = data_q[idx][{wsel, 5'b0} +: 32];
                        end
                    end else begin
                        stall_c = 1'b1;
                        state_d = (valid_q[idx] & dirty_q[idx]) ? WB : ALLOC;
                    end
                end
            end
            WB: begin
                // Request is withdrawn in the ack cycle so a gap separates WB from ALLOC.
                stall_c = 1'b1;
                req_c   = ~bus.mem_ack_i;
                we_c    = 1'b1;
                addr_c  = {tag_q[idx], idx, 5'b0};
                wdata_c = data_q[idx];
                if (bus.mem_ack_i) begin
                    state_d = ALLOC;
                end
            end
            ALLOC: begin
                stall_c = 1'b1;
                req_c   = ~bus.mem_ack_i;
                addr_c  = {addr_tag, idx, 5'b0};
                if (bus.mem_ack_i) begin
                    data_d[idx]  = bus.mem_rdata_i;
                    tag_d[idx]   = addr_tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage carries no reset; the valid bits make its contents irrelevant.
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    // Outputs are forced low while reset is held so a pending miss cannot stall or request.
    assign bus.cpu_rdata_o = rst_i ? rdata_c : '0;
    assign bus.cpu_stall_o = rst_i & stall_c;
    assign bus.mem_req_o   = rst_i & req_c;
    assign bus.mem_we_o    = rst_i & we_c;
    assign bus.mem_addr_o  = rst_i ? addr_c : '0;
    assign bus.mem_wdata_o = rst_i ? wdata_c : '0;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: cold miss, store hit, dirty and clean eviction,
// write-allocate store miss, long memory stall and reset during a refill.
module tb_dcache_controller;
    logic       clk_i;
    logic       rst_i;
    logic [1:0] dbg_state_o;
    int         n_checks;
    int         n_errors;
    int         stall_cnt;
    int         bad;
    logic [255:0] exp_line;

    dcache_controller_if bus ();

    dcache_controller dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .dbg_state_o (dbg_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
        return l;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        #1;
        if (bus.cpu_stall_o) stall_cnt++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic cpu(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
        bus.cpu_req_i   = req;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wdata;
    endtask

    // Plays one memory transaction: ack arrives in the lat-th cycle of the request.
    task automatic serve(input string nm, input logic exp_we, input logic [31:0] exp_addr,
                         input logic [255:0] exp_wdata, input int lat, input logic [255:0] line);
        #1;
        check({nm, " req"}, bus.mem_req_o, 1'b1);
        check({nm, " we"}, bus.mem_we_o, exp_we);
        check({nm, " addr"}, bus.mem_addr_o, exp_addr);
        if (exp_we) check({nm, " wdata"}, bus.mem_wdata_o, exp_wdata);
        bad = 0;
        for (int i = 1; i < lat; i++) begin
            tick();
            if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== exp_addr ||
                bus.mem_we_o !== exp_we || bus.cpu_stall_o !== 1'b1) bad++;
        end
        check({nm, " held"}, bad, 0);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = line;
        #1;
        check({nm, " ack-cycle req"}, bus.mem_req_o, 1'b0);
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        stall_cnt = 0;
        rst_i = 1'b0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        cpu(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        @(posedge clk_i);
        #3;
        check("reset stall", bus.cpu_stall_o, 1'b0);
        check("reset req", bus.mem_req_o, 1'b0);
        check("reset rdata", bus.cpu_rdata_o, 32'h0);
        check("reset state", dbg_state_o, 2'd0);
        tick();

        // 1: cold read of 0x40, ten-cycle memory latency
        rst_i = 1'b1;
        #1;
        check("cold miss stall", bus.cpu_stall_o, 1'b1);
        check("cold miss idle req", bus.mem_req_o, 1'b0);
        stall_cnt = 0;
        tick();
        check("cold alloc state", dbg_state_o, 2'd2);
        serve("cold alloc", 1'b0, 32'h0000_0040, '0, 10, make_line(32'h1111_0000));
        #1;
        check("cold hit stall", bus.cpu_stall_o, 1'b0);
        check("cold hit rdata", bus.cpu_rdata_o, 32'h1111_0000);
        check("cold stall cycles", stall_cnt, 11);

        // 2: store hit then reload
        cpu(1'b1, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
        #1;
        check("store hit stall", bus.cpu_stall_o, 1'b0);
        tick();
        cpu(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        #1;
        check("load 0x44", bus.cpu_rdata_o, 32'hDEAD_BEEF);
        cpu(1'b1, 1'b0, 32'h0000_0048, 32'h0);
        #1;
        check("load 0x48", bus.cpu_rdata_o, 32'h1111_0002);
        cpu(1'b0, 1'b0, 32'h0000_0048, 32'h0);
        #1;
        check("no req rdata", bus.cpu_rdata_o, 32'h0);
        check("no req stall", bus.cpu_stall_o, 1'b0);
        tick();

        // 3: conflicting load forces write-back of the dirty line
        cpu(1'b1, 1'b0, 32'h0000_0240, 32'h0);
        #1;
        check("dirty miss stall", bus.cpu_stall_o, 1'b1);
        stall_cnt = 0;
        tick();
        exp_line = make_line(32'h1111_0000);
        exp_line[63:32] = 32'hDEAD_BEEF;
        serve("dirty wb", 1'b1, 32'h0000_0040, exp_line, 3, '0);
        serve("dirty alloc", 1'b0, 32'h0000_0240, '0, 3, make_line(32'h2222_0000));
        #1;
        check("dirty hit rdata", bus.cpu_rdata_o, 32'h2222_0000);
        check("dirty stall cycles", stall_cnt, 7);
        tick();

        // 4: clean victim goes straight to ALLOC
        cpu(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        stall_cnt = 0;
        tick();
        check("clean miss state", dbg_state_o, 2'd2);
        serve("clean alloc", 1'b0, 32'h0000_0040, '0, 1, make_line(32'h3333_0000));
        #1;
        check("clean hit rdata", bus.cpu_rdata_o, 32'h3333_0000);
        check("clean stall cycles", stall_cnt, 2);
        tick();

        // ack outside a transaction is ignored
        cpu(1'b0, 1'b0, 32'h0000_0040, 32'h0);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = make_line(32'h9999_0000);
        #1;
        check("idle ack req", bus.mem_req_o, 1'b0);
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        check("idle ack state", dbg_state_o, 2'd0);
        cpu(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        #1;
        check("idle ack no refill", bus.cpu_rdata_o, 32'h3333_0001);
        tick();

        // write-allocate store miss, then evict it
        cpu(1'b1, 1'b1, 32'h0000_0460, 32'hCAFE_F00D);
        tick();
        serve("store alloc", 1'b0, 32'h0000_0460, '0, 2, make_line(32'h4444_0000));
        #1;
        check("store merge stall", bus.cpu_stall_o, 1'b0);
        tick();
        cpu(1'b1, 1'b0, 32'h0000_0464, 32'h0);
        #1;
        check("load 0x464", bus.cpu_rdata_o, 32'h4444_0001);
        cpu(1'b1, 1'b0, 32'h0000_0460, 32'h0);
        #1;
        check("load 0x460", bus.cpu_rdata_o, 32'hCAFE_F00D);
        tick();
        cpu(1'b1, 1'b0, 32'h0000_0060, 32'h0);
        tick();
        exp_line = make_line(32'h4444_0000);
        exp_line[31:0] = 32'hCAFE_F00D;
        serve("store evict wb", 1'b1, 32'h0000_0460, exp_line, 1, '0);
        serve("store evict alloc", 1'b0, 32'h0000_0060, '0, 1, make_line(32'h6666_0000));
        #1;
        check("load 0x60", bus.cpu_rdata_o, 32'h6666_0000);
        tick();

        // 5: memory silent for 100 cycles during ALLOC
        cpu(1'b1, 1'b0, 32'h0000_0640, 32'h0);
        tick();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_0640 ||
                bus.mem_we_o !== 1'b0 || bus.cpu_stall_o !== 1'b1) bad++;
            tick();
        end
        check("long hold stable", bad, 0);

        // 6: reset mid-refill
        #2;
        rst_i = 1'b0;
        #1;
        check("abort req", bus.mem_req_o, 1'b0);
        check("abort stall", bus.cpu_stall_o, 1'b0);
        check("abort state", dbg_state_o, 2'd0);
        tick();
        cpu(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        rst_i = 1'b1;
        #1;
        check("post reset miss", bus.cpu_stall_o, 1'b1);
        tick();
        serve("post reset alloc", 1'b0, 32'h0000_0040, '0, 2, make_line(32'h5555_0000));
        #1;
        check("post reset rdata", bus.cpu_rdata_o, 32'h5555_0000);
        cpu(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
